bcd_stopwatch_counter: RTL and testbench
========================================

BCD_STOPWATCH_COUNTER -- requirements
Module: bcd_stopwatch_counter

Interface
REQ-001 The block SHALL have parameter NUM_DIGITS, default 4, giving the number of BCD digits (range 2..8).
REQ-002 The block SHALL have parameter PRESCALE, default 10, giving the number of enb pulses per least-significant-digit increment (range 1..1024).
REQ-003 The block SHALL have parameter MOD6_MASK, default all zeros (NUM_DIGITS bits); bit i set makes digit i count modulo 6, clear makes it count modulo 10.
REQ-004 The block SHALL have parameter SAT_MODE, default 0; 0 wraps on full-scale overflow, 1 saturates.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-006 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-007 The block SHALL have port enb, input, 1 bit: time-base tick, one clk cycle wide.
REQ-008 The block SHALL have ports start, stop and clear, each input, 1 bit: single-cycle control pulses.
REQ-009 The block SHALL have port lap, input, 1 bit: lap hold/release pulse.
REQ-010 The block SHALL have port digits, output, 4*NUM_DIGITS bits: the live count, digit 0 in bits [3:0].
REQ-011 The block SHALL have port disp, output, 4*NUM_DIGITS bits: the display value, either live or held.
REQ-012 The block SHALL have ports running, overflow and lap_hold, each output, 1 bit.

Function
REQ-013 The block SHALL implement states IDLE, RUN, PAUSED and DONE; running SHALL be 1 only in RUN.
REQ-014 Transitions SHALL be: IDLE -start-> RUN; RUN -stop-> PAUSED; PAUSED -start-> RUN; RUN -saturating overflow-> DONE; any state -clear-> IDLE.
REQ-015 Control priority SHALL be clear > stop > start; any pulse that matches no transition in the current state SHALL be ignored.
REQ-016 In RUN, each enb pulse SHALL advance the prescaler; when the prescaler is at PRESCALE-1 it SHALL return to 0 and increment digit 0 in the same cycle.
REQ-017 Digit i SHALL increment when the digit below it carries; a digit at modulus-1 SHALL return to 0 and carry. The whole ripple SHALL settle within one cycle, so digits updates one clk after the qualifying enb.
REQ-018 enb SHALL be ignored in IDLE, PAUSED and DONE; the prescaler SHALL hold its value in PAUSED.
REQ-019 A carry out of the top digit with SAT_MODE=0 SHALL zero all digits, set overflow (sticky), and keep the state in RUN.
REQ-020 A carry out of the top digit with SAT_MODE=1 SHALL hold every digit at modulus-1, set overflow, and enter DONE.
REQ-021 clear SHALL zero the digits, prescaler, overflow and lap_hold in the next cycle, and SHALL win over a simultaneous enb.
REQ-022 disp SHALL equal digits whenever lap_hold is 0.
REQ-023 Digit values SHALL never exceed modulus-1.

Reset
REQ-024 rst_n low SHALL immediately force state IDLE, all digits 0, prescaler 0, disp 0, overflow 0, lap_hold 0 and running 0, independent of clk.
REQ-025 Counting SHALL resume only after a start pulse following reset release.

Configuration
REQ-026 With macro BCD_STOPWATCH_LAP_EN defined, a lap pulse in RUN or PAUSED while lap_hold=0 SHALL latch the current digits into a hold register and set lap_hold; a lap pulse while lap_hold=1 SHALL clear it. disp SHALL show the held value while lap_hold=1, and counting SHALL continue underneath.
REQ-027 Without BCD_STOPWATCH_LAP_EN, the lap input SHALL be ignored, lap_hold SHALL be tied to 0, disp SHALL equal digits, and no hold register SHALL exist.

Structure
REQ-028 Package bcd_stopwatch_pkg SHALL hold the state enum type, the 4-bit BCD digit typedef, and constants for modulus 10 and modulus 6.
REQ-029 Each digit SHALL be an instance of sub-module bcd_digit, parameter MODULUS, with ports inc, clr, sat, q and carry, generated NUM_DIGITS times.

Verification
REQ-030 Defaults; start, then 10 enb pulses -> digits=0x0001 one cycle after the 10th enb; 1000 further pulses -> digits=0x0101.
REQ-031 MOD6_MASK=4'b1000, PRESCALE=1; count from 0x5999 with one enb -> digits=0x0000 and overflow=1, state still RUN.
REQ-032 SAT_MODE=1, PRESCALE=1, at 0x9999 -> one enb -> digits stay 0x9999, overflow=1, running=0; further start ignored; clear -> 0x0000, IDLE.
REQ-033 Running, stop with prescaler=7, then 5 enb, then start and 3 enb -> digit 0 increments exactly once, on the 3rd enb after start.
REQ-034 clear and enb in the same cycle at 0x0009, prescaler=9 -> digits=0x0000, never 0x0010; rst_n low mid-count -> outputs zero asynchronously, before the next clk edge.
REQ-035 With BCD_STOPWATCH_LAP_EN: lap at 0x0042 -> disp frozen at 0x0042 while digits advances; second lap -> disp tracks digits in the next cycle.

Source files
------------

// File: rtl/bcd_stopwatch_pkg.sv
// Shared types and constants for the BCD stopwatch counter and its digit cells.
package bcd_stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_DONE   = 2'd3
    } sw_state_e;

    typedef logic [3:0] bcd_t;

    localparam int unsigned MOD10 = 10;
    localparam int unsigned MOD6  = 6;

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit counting modulo MODULUS; carry is combinational so a whole
// chain of digits ripples within a single clock cycle.
module bcd_digit
    import bcd_stopwatch_pkg::*;
#(
    parameter int unsigned MODULUS = MOD10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic clr,
    input  logic sat,
    output bcd_t q,
    output logic carry
);

    localparam bcd_t MAX = bcd_t'(MODULUS - 1);

    bcd_t q_q, q_d;

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (sat) begin
            q_d = MAX;
        end else if (inc) begin
            q_d = (q_q == MAX) ? '0 : q_q + 4'd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops sample together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q     = q_q;
    assign carry = inc && (q_q == MAX);

endmodule

// File: rtl/bcd_stopwatch_counter.sv
// Stopwatch: prescaled BCD digit chain with start/stop/clear control.
// Optional lap hold register enabled by defining BCD_STOPWATCH_LAP_EN.
module bcd_stopwatch_counter
    import bcd_stopwatch_pkg::*;
#(
    parameter int unsigned           NUM_DIGITS = 4,
    parameter int unsigned           PRESCALE   = 10,
    parameter logic [NUM_DIGITS-1:0] MOD6_MASK  = '0,
    parameter int unsigned           SAT_MODE   = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enb,
    input  logic                    start,
    input  logic                    stop,
    input  logic                    clear,
    input  logic                    lap,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic [4*NUM_DIGITS-1:0] disp,
    output logic                    running,
    output logic                    overflow,
    output logic                    lap_hold
);

    localparam int unsigned      PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
    localparam bit               SAT_EN   = (SAT_MODE != 0);

    sw_state_e               state_q, state_d;
    logic [PRE_W-1:0]        pre_q, pre_d;
    logic                    ovf_q, ovf_d;
    logic                    count_en, tick, top_carry, sat_hit;
    logic [4*NUM_DIGITS-1:0] count;

    assign count_en = (state_q == ST_RUN) && enb && !clear;

    always_comb begin
        pre_d = pre_q;
        tick  = 1'b0;
        if (clear) begin
            pre_d = '0;
        end else if (count_en) begin
            if (pre_q == PRE_LAST) begin
                pre_d = '0;
                tick  = 1'b1;
            end else begin
                pre_d = pre_q + 1'b1;
            end
        end
    end

    // Each digit's increment is the carry of the digit below; digit 0 takes the prescaler tick.
    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        localparam int unsigned MODULUS = MOD6_MASK[i] ? MOD6 : MOD10;
        logic inc;
        logic carry;
        if (i == 0) begin : g_lsd
            assign inc = tick;
        end else begin : g_upper
            assign inc = g_digit[i-1].carry;
        end
        bcd_digit #(
            .MODULUS(MODULUS)
        ) u_digit (
            .clk  (clk),
            .rst_n(rst_n),
            .inc  (inc),
            .clr  (clear),
            .sat  (sat_hit),
            .q    (count[4*i +: 4]),
            .carry(carry)
        );
    end

    assign top_carry = g_digit[NUM_DIGITS-1].carry;
    assign sat_hit   = SAT_EN && top_carry;
    assign ovf_d     = clear ? 1'b0 : (ovf_q || top_carry);

    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) state_d = ST_RUN;
                end
                ST_RUN: begin
                    if (sat_hit)   state_d = ST_DONE;
                    else if (stop) state_d = ST_PAUSED;
                end
                ST_PAUSED: begin
                    if (start) state_d = ST_RUN;
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pre_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            ovf_q   <= ovf_d;
        end
    end

    assign digits   = count;
    assign running  = (state_q == ST_RUN);
    assign overflow = ovf_q;

`ifdef BCD_STOPWATCH_LAP_EN
    logic                    lap_hold_q, lap_hold_d;
    logic [4*NUM_DIGITS-1:0] hold_q, hold_d;

    always_comb begin
        lap_hold_d = lap_hold_q;
        hold_d     = hold_q;
        if (clear) begin
            lap_hold_d = 1'b0;
        end else if (lap) begin
            if (lap_hold_q) begin
                lap_hold_d = 1'b0;
            end else if (state_q == ST_RUN || state_q == ST_PAUSED) begin
                hold_d     = count;
                lap_hold_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lap_hold_q <= 1'b0;
        end else begin
            lap_hold_q <= lap_hold_d;
        end
    end

    // NOTE: the hold data register is not reset; disp only shows it after a capture sets lap_hold.
    always_ff @(posedge clk) begin
        hold_q <= hold_d;
    end

    assign lap_hold = lap_hold_q;
    assign disp     = lap_hold_q ? hold_q : count;
`else
    logic lap_unused;
    assign lap_unused = lap;
    assign lap_hold   = 1'b0;
    assign disp       = count;
`endif

endmodule

// File: tb/tb_bcd_stopwatch_counter.sv
// Scoreboard bench: three stopwatch configurations share one random/directed
// stimulus stream and are checked against an integer-count reference model.
module tb_bcd_stopwatch_counter;

    localparam int NI = 3;
    localparam int ND = 4;
    localparam int S_IDLE = 0, S_RUN = 1, S_PAUSED = 2, S_DONE = 3;
`ifdef BCD_STOPWATCH_LAP_EN
    localparam bit LAP_EN = 1'b1;
`else
    localparam bit LAP_EN = 1'b0;
`endif

    logic clk;
    logic rst_n, enb, start, stop, clear, lap;
    logic [NI-1:0][15:0] dig_w, disp_w;
    logic [NI-1:0]       run_w, ovf_w, lh_w;

    typedef struct packed {
        logic [NI-1:0][15:0] digits;
        logic [NI-1:0][15:0] disp;
        logic [NI-1:0]       running;
        logic [NI-1:0]       overflow;
        logic [NI-1:0]       lap_hold;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    int m_state [NI];
    int m_pre   [NI];
    int m_count [NI];
    int m_hold  [NI];
    bit m_ovf   [NI];
    bit m_lhold [NI];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    bcd_stopwatch_counter u0 (
        .clk(clk), .rst_n(rst_n), .enb(enb), .start(start), .stop(stop), .clear(clear), .lap(lap),
        .digits(dig_w[0]), .disp(disp_w[0]), .running(run_w[0]), .overflow(ovf_w[0]), .lap_hold(lh_w[0])
    );

    bcd_stopwatch_counter #(.NUM_DIGITS(4), .PRESCALE(1), .MOD6_MASK(4'b1000), .SAT_MODE(0)) u1 (
        .clk(clk), .rst_n(rst_n), .enb(enb), .start(start), .stop(stop), .clear(clear), .lap(lap),
        .digits(dig_w[1]), .disp(disp_w[1]), .running(run_w[1]), .overflow(ovf_w[1]), .lap_hold(lh_w[1])
    );

    bcd_stopwatch_counter #(.NUM_DIGITS(4), .PRESCALE(1), .MOD6_MASK(4'b0000), .SAT_MODE(1)) u2 (
        .clk(clk), .rst_n(rst_n), .enb(enb), .start(start), .stop(stop), .clear(clear), .lap(lap),
        .digits(dig_w[2]), .disp(disp_w[2]), .running(run_w[2]), .overflow(ovf_w[2]), .lap_hold(lh_w[2])
    );

    function automatic int pre_of(int k);
        return (k == 0) ? 10 : 1;
    endfunction

    function automatic int modulus(int k, int i);
        return (k == 1 && i == 3) ? 6 : 10;
    endfunction

    function automatic int full_scale(int k);
        int f = 1;
        for (int i = 0; i < ND; i++) f = f * modulus(k, i);
        return f;
    endfunction

    function automatic logic [15:0] to_bcd(int k, int value);
        logic [15:0] r = '0;
        int v = value;
        for (int i = 0; i < ND; i++) begin
            r[4*i +: 4] = 4'(v % modulus(k, i));
            v = v / modulus(k, i);
        end
        return r;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NI; k++) begin
            m_state[k] = S_IDLE; m_pre[k] = 0; m_count[k] = 0;
            m_hold[k] = 0; m_ovf[k] = 1'b0; m_lhold[k] = 1'b0;
        end
    endtask

    // Behaviour expressed on an integer elapsed-tick count, not on digits.
    task automatic model_step(input int k, input bit e, input bit s, input bit p, input bit c, input bit l);
        int old = m_state[k];
        bit saturated = 1'b0;
        if (c) begin
            m_state[k] = S_IDLE; m_pre[k] = 0; m_count[k] = 0;
            m_ovf[k] = 1'b0; m_lhold[k] = 1'b0;
            return;
        end
        if (LAP_EN && l) begin
            if (m_lhold[k]) m_lhold[k] = 1'b0;
            else if (old == S_RUN || old == S_PAUSED) begin
                m_hold[k] = m_count[k];
                m_lhold[k] = 1'b1;
            end
        end
        if (old == S_RUN && e) begin
            if (m_pre[k] == pre_of(k) - 1) begin
                m_pre[k] = 0;
                if (m_count[k] == full_scale(k) - 1) begin
                    m_ovf[k] = 1'b1;
                    if (k == 2) saturated = 1'b1;
                    else m_count[k] = 0;
                end else begin
                    m_count[k] = m_count[k] + 1;
                end
            end else begin
                m_pre[k] = m_pre[k] + 1;
            end
        end
        case (old)
            S_IDLE:   if (s) m_state[k] = S_RUN;
            S_RUN:    if (saturated) m_state[k] = S_DONE; else if (p) m_state[k] = S_PAUSED;
            S_PAUSED: if (s) m_state[k] = S_RUN;
            default:  ;
        endcase
    endtask

    function automatic exp_t model_outputs();
        exp_t x;
        for (int k = 0; k < NI; k++) begin
            x.digits[k]   = to_bcd(k, m_count[k]);
            x.disp[k]     = m_lhold[k] ? to_bcd(k, m_hold[k]) : to_bcd(k, m_count[k]);
            x.running[k]  = (m_state[k] == S_RUN);
            x.overflow[k] = m_ovf[k];
            x.lap_hold[k] = m_lhold[k];
        end
        return x;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle(input bit e, input bit s, input bit p, input bit c, input bit l);
        @(negedge clk);
        enb = e; start = s; stop = p; clear = c; lap = l;
        for (int k = 0; k < NI; k++) model_step(k, e, s, p, c, l);
        sb_q.push_back(model_outputs());
        @(posedge clk);
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic check_all_zero(input string tag);
        for (int k = 0; k < NI; k++) begin
            check($sformatf("%s_digits_u%0d", tag, k), 32'(dig_w[k]), 32'h0);
            check($sformatf("%s_disp_u%0d", tag, k), 32'(disp_w[k]), 32'h0);
            check($sformatf("%s_running_u%0d", tag, k), 32'(run_w[k]), 32'h0);
            check($sformatf("%s_overflow_u%0d", tag, k), 32'(ovf_w[k]), 32'h0);
            check($sformatf("%s_lap_hold_u%0d", tag, k), 32'(lh_w[k]), 32'h0);
        end
    endtask

    // Asserts rst_n between clock edges and samples before the next rising edge.
    task automatic async_reset();
        @(negedge clk);
        enb = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0; lap = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        model_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    always begin : monitor
        exp_t x;
        @(posedge clk);
        #1;
        if (sb_q.size() != 0) begin
            x = sb_q.pop_front();
            for (int k = 0; k < NI; k++) begin
                check($sformatf("sb_digits_u%0d", k), 32'(dig_w[k]), 32'(x.digits[k]));
                check($sformatf("sb_disp_u%0d", k), 32'(disp_w[k]), 32'(x.disp[k]));
                check($sformatf("sb_running_u%0d", k), 32'(run_w[k]), 32'(x.running[k]));
                check($sformatf("sb_overflow_u%0d", k), 32'(ovf_w[k]), 32'(x.overflow[k]));
                check($sformatf("sb_lap_hold_u%0d", k), 32'(lh_w[k]), 32'(x.lap_hold[k]));
            end
        end
    end

    initial begin
        rst_n = 1'b0; enb = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0; lap = 1'b0;
        model_reset();
        #1;
        check_all_zero("por");
        @(negedge clk);
        #2;
        rst_n = 1'b1;

        // enb before any start is ignored
        repeat (5) cycle(1, 0, 0, 0, 0);
        settle();
        check("idle_ignores_enb", 32'(dig_w[0]), 32'h0);

        cycle(0, 1, 0, 0, 0);
        repeat (10) cycle(1, 0, 0, 0, 0);
        settle();
        check("ten_pulses_u0", 32'(dig_w[0]), 32'h0001);
        repeat (1000) cycle(1, 0, 0, 0, 0);
        settle();
        check("1010_pulses_u0", 32'(dig_w[0]), 32'h0101);

        // modulo-6 top digit wraps at 5999
        cycle(0, 0, 0, 1, 0);
        cycle(0, 1, 0, 0, 0);
        repeat (5999) cycle(1, 0, 0, 0, 0);
        settle();
        check("mod6_at_5999_u1", 32'(dig_w[1]), 32'h5999);
        cycle(1, 0, 0, 0, 0);
        settle();
        check("mod6_wrap_digits_u1", 32'(dig_w[1]), 32'h0000);
        check("mod6_wrap_ovf_u1", 32'(ovf_w[1]), 32'h1);
        check("mod6_wrap_running_u1", 32'(run_w[1]), 32'h1);

        // saturation at 9999
        cycle(0, 0, 0, 1, 0);
        cycle(0, 1, 0, 0, 0);
        repeat (9999) cycle(1, 0, 0, 0, 0);
        settle();
        check("sat_at_9999_u2", 32'(dig_w[2]), 32'h9999);
        check("sat_pre_ovf_u2", 32'(ovf_w[2]), 32'h0);
        cycle(1, 0, 0, 0, 0);
        settle();
        check("sat_hold_digits_u2", 32'(dig_w[2]), 32'h9999);
        check("sat_ovf_u2", 32'(ovf_w[2]), 32'h1);
        check("sat_running_u2", 32'(run_w[2]), 32'h0);
        cycle(0, 1, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        settle();
        check("done_ignores_start_u2", 32'(run_w[2]), 32'h0);
        check("done_ignores_enb_u2", 32'(dig_w[2]), 32'h9999);
        cycle(0, 0, 0, 1, 0);
        settle();
        check("done_clear_digits_u2", 32'(dig_w[2]), 32'h0000);
        check("done_clear_ovf_u2", 32'(ovf_w[2]), 32'h0);

        // pause preserves prescaler phase
        cycle(0, 1, 0, 0, 0);
        repeat (7) cycle(1, 0, 0, 0, 0);
        cycle(0, 0, 1, 0, 0);
        repeat (5) cycle(1, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        settle();
        check("pause_second_enb_u0", 32'(dig_w[0]), 32'h0000);
        cycle(1, 0, 0, 0, 0);
        settle();
        check("pause_third_enb_u0", 32'(dig_w[0]), 32'h0001);

        // clear wins over a simultaneous enb at 0009 / prescaler 9
        cycle(0, 0, 0, 1, 0);
        cycle(0, 1, 0, 0, 0);
        repeat (99) cycle(1, 0, 0, 0, 0);
        settle();
        check("pre_clear_u0", 32'(dig_w[0]), 32'h0009);
        cycle(1, 0, 0, 1, 0);
        settle();
        check("clear_beats_enb_u0", 32'(dig_w[0]), 32'h0000);

        cycle(0, 1, 0, 0, 0);
        repeat (37) cycle(1, 0, 0, 0, 0);
        async_reset();
        repeat (4) cycle(1, 0, 0, 0, 0);
        settle();
        check("post_reset_needs_start_u1", 32'(dig_w[1]), 32'h0000);

`ifdef BCD_STOPWATCH_LAP_EN
        cycle(0, 0, 0, 1, 0);
        cycle(0, 1, 0, 0, 0);
        repeat (420) cycle(1, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 1);
        repeat (20) cycle(1, 0, 0, 0, 0);
        settle();
        check("lap_frozen_disp_u0", 32'(disp_w[0]), 32'h0042);
        check("lap_live_digits_u0", 32'(dig_w[0]), 32'h0044);
        check("lap_hold_set_u0", 32'(lh_w[0]), 32'h1);
        cycle(0, 0, 0, 0, 1);
        settle();
        check("lap_release_disp_u0", 32'(disp_w[0]), 32'h0044);
`endif

        // randomized traffic
        cycle(0, 1, 0, 0, 0);
        for (int n = 0; n < 3000; n++) begin
            if (n == 1500) async_reset();
            cycle(1'($urandom % 2),
                  ($urandom % 16) == 0,
                  ($urandom % 24) == 0,
                  ($urandom % 128) == 0,
                  ($urandom % 20) == 0);
        end
        cycle(0, 0, 0, 0, 0);
        settle();
        check("scoreboard_drained", 32'(sb_q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
